// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction memory with byte-serial program loader
// Purpose: word-addressed instruction memory that answers fetch requests combinationally.
//   Its contents are written through a byte-serial load port. A three-state loader
//   (IDLE/LOAD/DONE) packs the incoming bytes into little-endian words.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   instr_addr      fetch byte address; instr_data is the combinational read word
//   ld_start        begin/restart a load at word 0
//   ld_valid/ld_ready/ld_byte/ld_last   byte stream handshake, ld_last marks the final byte
//   load_done       high while in DONE
//   load_err        sticky overflow flag for the current/last load
//   words_loaded    words written by the current/last load
//   fetch_misalign  (IMEM_FETCH_GUARD_EN only) sticky misaligned-fetch flag
// Config: IMEM_FETCH_GUARD_EN gates fetches to NOP_WORD outside DONE and on misaligned addresses.
module instr_mem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_addr,
  output logic [31:0]       instr_data,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              load_done,
  output logic              load_err,
`ifdef IMEM_FETCH_GUARD_EN
  output logic              fetch_misalign,
`endif
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        byte_cnt;
  // Lower three bytes of the word being assembled; unfilled bytes are kept at zero
  logic [23:0]       word_buf;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              wr_full;
  logic              wr_en;
  logic              at_last_slot;
  logic [31:0]       wr_word;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_oob;
  logic [31:0]       raw_word;

  assign ld_ready     = (state == S_LOAD) && !ld_start;
  assign accept       = ld_valid && ld_ready;
  assign wr_full      = accept && (byte_cnt == 2'd3);
  assign wr_en        = accept && ((byte_cnt == 2'd3) || ld_last);
  assign at_last_slot = (wr_ptr == ADDR_W'(DEPTH_WORDS - 1));
  assign load_done    = (state == S_DONE);

  // Current byte is merged into lane byte_cnt. Higher lanes stay zero, so a short
  // final word has its unfilled upper bytes cleared.
  assign wr_word = {8'h00, word_buf} | ({24'h000000, ld_byte} << {byte_cnt, 3'b000});

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ld_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (ld_start)                    state_nxt = S_LOAD;
        else if (accept && ld_last)      state_nxt = S_DONE;
        else if (wr_full && at_last_slot) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (ld_start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
      words_loaded <= '0;
      load_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_start) begin
        // ld_start always lands in LOAD, so it always starts a fresh image
        wr_ptr       <= '0;
        byte_cnt     <= '0;
        word_buf     <= '0;
        words_loaded <= '0;
        load_err     <= 1'b0;
      end else if (accept) begin
        if (wr_en) begin
          wr_ptr       <= wr_ptr + ADDR_W'(1);
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          byte_cnt     <= '0;
          word_buf     <= '0;
          // A full word was written into the last slot, and the image is still not finished
          if (!ld_last && at_last_slot) load_err <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          word_buf <= wr_word[23:0];
        end
      end
    end
  end

  // The array is not reset. The write is held off during reset, so a reset that
  // arrives mid-load cannot commit a word.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_ptr] <= wr_word;
  end

  assign rd_idx   = instr_addr[ADDR_W+1:2];
  assign rd_oob   = (instr_addr >> (ADDR_W + 2)) != 32'd0;
  assign raw_word = mem[rd_idx];

`ifdef IMEM_FETCH_GUARD_EN
  assign instr_data = (rd_oob || (state != S_DONE) || (instr_addr[1:0] != 2'b00))
                      ? NOP_WORD : raw_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_misalign <= 1'b0;
    end else if (ld_start) begin
      fetch_misalign <= 1'b0;
    end else if ((state == S_DONE) && (instr_addr[1:0] != 2'b00)) begin
      fetch_misalign <= 1'b1;
    end
  end
`else
  assign instr_data = rd_oob ? NOP_WORD : raw_word;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^instr_addr[1:0];
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
// Purpose: drives load images into a default-size instance and a 4-word instance.
//   It checks read-back words, loader status, restart, reset and overflow.
// Ports: none (top-level bench)
// Config: checks for IMEM_FETCH_GUARD_EN are compiled in when that macro is defined.
module tb_instr_mem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;

  logic [31:0] ia0, id0;
  logic        st0, v0, r0, l0, done0, err0;
  logic [7:0]  b0;
  logic [10:0] wl0;

  logic [31:0] ia1, id1;
  logic        st1, v1, r1, l1, done1, err1;
  logic [7:0]  b1;
  logic [2:0]  wl1;

`ifdef IMEM_FETCH_GUARD_EN
  logic        fm0, fm1;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp1_q[$];
  logic [31:0] m_word;
  logic [31:0] m_addr;
  int          m_k;

  int          errors = 0;
  int          checks = 0;

  instr_mem_loader u0 (
    .clk(clk), .rst(rst), .instr_addr(ia0), .instr_data(id0),
    .ld_start(st0), .ld_valid(v0), .ld_ready(r0), .ld_byte(b0), .ld_last(l0),
    .load_done(done0), .load_err(err0),
`ifdef IMEM_FETCH_GUARD_EN
    .fetch_misalign(fm0),
`endif
    .words_loaded(wl0)
  );

  instr_mem_loader #(.DEPTH_WORDS(4), .ADDR_W(2)) u1 (
    .clk(clk), .rst(rst), .instr_addr(ia1), .instr_data(id1),
    .ld_start(st1), .ld_valid(v1), .ld_ready(r1), .ld_byte(b1), .ld_last(l1),
    .load_done(done1), .load_err(err1),
`ifdef IMEM_FETCH_GUARD_EN
    .fetch_misalign(fm1),
`endif
    .words_loaded(wl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_word = '0;
    m_addr = '0;
    m_k    = 0;
    exp_q.delete();
  endtask

  task automatic start0();
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    model_clear();
  endtask

  // Offer one byte to u0, waiting a bounded time for ld_ready, and update the packing model
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n  = 0;
    v0 = 1'b1;
    b0 = b;
    l0 = last;
    #1;
    while (!r0 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ld_ready_wait", {31'b0, r0}, 32'd1);
    @(posedge clk); #1;
    v0 = 1'b0;
    l0 = 1'b0;
    m_word = m_word | ({24'b0, b} << (8 * m_k));
    if (m_k == 3 || last) begin
      exp_q.push_back({m_addr, m_word});
      m_addr++;
      m_word = '0;
      m_k    = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic readback(input int sel);
    exp_t e;
    if (sel == 0) begin
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        ia0 = e.addr << 2;
        #1;
        chk("readback_u0", id0, e.word);
      end
    end else begin
      while (exp1_q.size() > 0) begin
        e   = exp1_q.pop_front();
        ia1 = e.addr << 2;
        #1;
        chk("readback_u1", id1, e.word);
      end
    end
  endtask

  initial begin
    int          acc;
    logic [31:0] w1;
    logic [7:0]  img1 [8];
    logic [7:0]  img2 [6];

    img1 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    rst = 1'b0;
    ia0 = '0; st0 = 1'b0; v0 = 1'b0; b0 = '0; l0 = 1'b0;
    ia1 = '0; st1 = 1'b0; v1 = 1'b0; b1 = '0; l1 = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", {31'b0, done0}, 32'd0);
    chk("rst_err", {31'b0, err0}, 32'd0);
    chk("rst_words", 32'(wl0), 32'd0);
    chk("rst_ready", {31'b0, r0}, 32'd0);
`ifdef IMEM_FETCH_GUARD_EN
    chk("rst_misalign", {31'b0, fm0}, 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // Two full words
    start0();
    for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
    chk("t1_done", {31'b0, done0}, 32'd1);
    chk("t1_err", {31'b0, err0}, 32'd0);
    chk("t1_words", 32'(wl0), 32'd2);
    chk("t1_ready_done", {31'b0, r0}, 32'd0);
    readback(0);
    ia0 = 32'h0; #1;
    chk("t1_word0", id0, 32'h0050_0013);
    ia0 = 32'h4; #1;
    chk("t1_word1", id0, 32'h0010_0093);

    // Out-of-range and misaligned fetches
    ia0 = 32'h0000_1000; #1;
    chk("t4_oob", id0, NOP);
    ia0 = 32'h0000_0006; #1;
`ifdef IMEM_FETCH_GUARD_EN
    chk("t6_misalign_nop", id0, NOP);
    @(posedge clk); #1;
    ia0 = 32'h0;
    @(posedge clk); #1;
    chk("t6_misalign_sticky", {31'b0, fm0}, 32'd1);
`else
    chk("t4_lowbits_ignored", id0, 32'h0010_0093);
`endif

    // Partial final word
    start0();
`ifdef IMEM_FETCH_GUARD_EN
    ia0 = 32'h0; #1;
    chk("t6_load_nop", id0, NOP);
    chk("t6_misalign_clr", {31'b0, fm0}, 32'd0);
`endif
    for (int i = 0; i < 6; i++) send_byte(img2[i], i == 5);
    chk("t2_words", 32'(wl0), 32'd2);
    chk("t2_done", {31'b0, done0}, 32'd1);
    readback(0);
    ia0 = 32'h4; #1;
    chk("t2_partial", id0, 32'h0000_FFEE);

    // Restart mid-load: the byte presented with ld_start is refused
    start0();
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0);
    st0 = 1'b1; v0 = 1'b1; b0 = 8'hFF; #1;
    chk("t5_ready_on_start", {31'b0, r0}, 32'd0);
    @(posedge clk); #1;
    st0 = 1'b0; v0 = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), i == 3);
    chk("t5_words", 32'(wl0), 32'd1);
    readback(0);
    ia0 = 32'h0; #1;
    chk("t5_word0", id0, 32'h0403_0201);

    // Reset mid-load
    start0();
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_done", {31'b0, done0}, 32'd0);
    chk("t5_rst_ready", {31'b0, r0}, 32'd0);
    chk("t5_rst_words", 32'(wl0), 32'd0);
    ia0 = 32'h0; #1;
`ifdef IMEM_FETCH_GUARD_EN
    chk("t6_idle_nop", id0, NOP);
`else
    chk("t5_rst_keeps_mem", id0, 32'h0403_0201);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // Overflow on the 4-word instance
    st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    exp1_q.delete();
    acc = 0;
    w1  = '0;
    for (int i = 0; i < 20; i++) begin
      v1 = 1'b1;
      b1 = 8'(i + 1);
      l1 = 1'b0;
      #1;
      if (r1) begin
        w1 = w1 | ({24'b0, b1} << (8 * (acc % 4)));
        if (acc % 4 == 3) begin
          exp1_q.push_back({32'(acc / 4), w1});
          w1 = '0;
        end
        acc++;
      end
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    chk("t3_accepted", 32'(acc), 32'd16);
    chk("t3_err", {31'b0, err1}, 32'd1);
    chk("t3_done", {31'b0, done1}, 32'd1);
    chk("t3_ready", {31'b0, r1}, 32'd0);
    chk("t3_words", 32'(wl1), 32'd4);
    readback(1);
    ia1 = 32'hC; #1;
    chk("t3_word3", id1, 32'h100F_0E0D);
    ia1 = 32'h10; #1;
    chk("t3_oob", id1, NOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
